// File: rtl/filt_sched_pkg.sv
// Shared definitions for the two-stage filter scheduler.
// Holds the FSM state encoding, the default hold/timeout constants and a
// small helper that sizes the cycle counters.
package filt_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrig1,
    StWait1,
    StCap1,
    StTrig2,
    StWait2,
    StCap2,
    StHold
  } state_e;

  localparam int unsigned HoldCycDefault = 3;
  localparam int unsigned TimeoutDefault = 8;

  // Width of a counter that runs from 0 to n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/filter_sched_wait_timer.sv
// wait_timer: counts cycles spent in a WAIT state.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   clear       zero the count (asserted the cycle before WAIT entry)
//   enable      advance the count by one this cycle
//   reached     high while the count is on its Limit-th cycle
module wait_timer
  import filt_sched_pkg::*;
#(
  parameter int unsigned Limit = TimeoutDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic reached
);

  localparam int unsigned CntW = cnt_width(Limit);
  localparam logic [CntW-1:0] Last = CntW'((Limit == 0) ? 0 : Limit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q == k on the (k+1)-th enabled cycle, so Last marks the Limit-th one.
  assign reached = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !reached) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/filter_sched.sv
// filter_sched: sequences one sample through two external notch stages.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   frame_valid, x_in    new-sample strobe and sample
//   stage_en[1:0]        per-stage enable (0 = bypass that stage)
//   err_clr              clears the sticky overrun / timeout_err flags
//   trig1/2, done1/2     sample trigger to / done from each stage
//   st1_din/st2_din      data to each stage; st1_dout/st2_dout data back
//   y_out, out_valid     cascade result and its one-cycle strobe
//   busy                 FSM not idle
//   overrun, timeout_err sticky error flags
module filter_sched
  import filt_sched_pkg::*;
#(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned HOLD_CYC = HoldCycDefault,
  parameter int unsigned TIMEOUT  = TimeoutDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_valid,
  input  logic [DATA_W-1:0] x_in,
  input  logic [1:0]        stage_en,
  input  logic              err_clr,
  output logic              trig1,
  output logic              trig2,
  input  logic              done1,
  input  logic              done2,
  output logic [DATA_W-1:0] st1_din,
  output logic [DATA_W-1:0] st2_din,
  input  logic [DATA_W-1:0] st1_dout,
  input  logic [DATA_W-1:0] st2_dout,
  output logic [DATA_W-1:0] y_out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int unsigned HoldW = cnt_width(HOLD_CYC);
  localparam logic [HoldW-1:0] HoldLast = HoldW'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q, s1_q, y_q;
  logic [1:0]        en_q;
  logic [HoldW-1:0]  hold_cnt_q;
  logic              out_valid_q, overrun_q, timeout_q;
  logic              timer_clear, timer_en, timer_hit, timeout_evt;
  logic              accept, overrun_evt;

  wait_timer #(
    .Limit(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .reached(timer_hit)
  );

  assign accept      = (state_q == StIdle) && frame_valid;
  assign overrun_evt = (state_q != StIdle) && frame_valid;

  always_comb begin
    state_d     = state_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    timeout_evt = 1'b0;
    unique case (state_q)
      StIdle:  if (frame_valid) state_d = StTrig1;
      StTrig1: begin
        timer_clear = 1'b1;
        state_d     = en_q[0] ? StWait1 : StCap1;
      end
      StWait1: begin
        timer_en = 1'b1;
        // done beats a timeout landing on the same cycle
        if (done1) begin
          state_d = StCap1;
        end else if (timer_hit) begin
          timeout_evt = 1'b1;
          state_d     = StIdle;
        end
      end
      StCap1:  state_d = StTrig2;
      StTrig2: begin
        timer_clear = 1'b1;
        state_d     = en_q[1] ? StWait2 : StCap2;
      end
      StWait2: begin
        timer_en = 1'b1;
        if (done2) begin
          state_d = StCap2;
        end else if (timer_hit) begin
          timeout_evt = 1'b1;
          state_d     = StIdle;
        end
      end
      StCap2:  state_d = (HOLD_CYC == 0) ? StIdle : StHold;
      StHold:  if (hold_cnt_q == HoldLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      x_q         <= '0;
      s1_q        <= '0;
      y_q         <= '0;
      en_q        <= '0;
      hold_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q  <= x_in;
        en_q <= stage_en;
      end
      if (state_q == StCap1) s1_q <= en_q[0] ? st1_dout : x_q;
      if (state_q == StCap2) y_q <= en_q[1] ? st2_dout : s1_q;
      out_valid_q <= (state_q == StCap2);
      if (state_q == StCap2) begin
        hold_cnt_q <= '0;
      end else if (state_q == StHold && hold_cnt_q != HoldLast) begin
        hold_cnt_q <= hold_cnt_q + HoldW'(1);
      end
      // A new error event outranks a simultaneous clear.
      if (overrun_evt) overrun_q <= 1'b1;
      else if (err_clr) overrun_q <= 1'b0;
      if (timeout_evt) timeout_q <= 1'b1;
      else if (err_clr) timeout_q <= 1'b0;
    end
  end

  assign trig1       = (state_q == StTrig1) && en_q[0];
  assign trig2       = (state_q == StTrig2) && en_q[1];
  assign st1_din     = x_q;
  assign st2_din     = s1_q;
  assign y_out       = y_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q != StIdle);
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: doc/filter_sched.md
FILTER_SCHED -- requirements
Module: filter_sched

Interface
REQ-001 Parameter DATA_W, default 24: sample width, two's complement.
REQ-002 Parameter HOLD_CYC, default 3: post-stage-2 hold cycles before next accept.
REQ-003 Parameter TIMEOUT, default 8: max cycles in a WAIT state before abort.
REQ-004 clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-005 frame_valid  in  1  new input sample strobe; x_in  in  DATA_W  input sample.
REQ-006 stage_en  in  2  per-stage enable, bit0 = stage 1, bit1 = stage 2; 0 = bypass.
REQ-007 err_clr  in  1  clears sticky error flags.
REQ-008 trig1/trig2  out  1  sample_trig to notch stage 1/2.
REQ-009 done1/done2  in  1  filter_done from stage 1/2.
REQ-010 st1_din/st2_din  out  DATA_W  data_in to stage 1/2; st1_dout/st2_dout  in  DATA_W  data_out from stage 1/2.
REQ-011 y_out  out  DATA_W  cascade result; out_valid  out  1  one-cycle result strobe.
REQ-012 busy  out  1  high when FSM not IDLE; overrun  out  1  sticky; timeout_err  out  1  sticky.

Function
REQ-013 FSM states: IDLE, TRIG1, WAIT1, CAP1, TRIG2, WAIT2, CAP2, HOLD.
REQ-014 IDLE with frame_valid=1: latch x_in into x_reg and stage_en into en_reg; go to TRIG1.
REQ-015 TRIG1: trig1=1 for exactly this cycle if en_reg[0]; next WAIT1; if en_reg[0]=0, no trig, next CAP1.
REQ-016 WAIT1: stay until done1=1, then CAP1.
REQ-017 CAP1: s1_reg <= st1_dout if en_reg[0], else x_reg; next TRIG2.
REQ-018 TRIG2/WAIT2/CAP2 mirror stage 1 using trig2, done2, st2_dout, en_reg[1], bypass source s1_reg.
REQ-019 Leaving CAP2: y_out <= captured value, out_valid=1 for the next cycle only; go to HOLD.
REQ-020 HOLD lasts exactly HOLD_CYC cycles, then IDLE.
REQ-021 st1_din = x_reg, st2_din = s1_reg, both constant from accept until the next accept (covers stage S4 reuse of data_in).
REQ-022 Both stages enabled, done one cycle after trig: accept c0, trig1 c1, trig2 c4, out_valid c7, IDLE c10; min frame period 10 cycles.
REQ-023 Each WAIT has a cycle counter cleared on WAIT entry; on the TIMEOUT-th WAIT cycle without done: set timeout_err, go to IDLE, no out_valid, y_out unchanged.
REQ-024 done on the same cycle the counter reaches TIMEOUT: done wins, no timeout.
REQ-025 frame_valid in any non-IDLE state: sample dropped, overrun set, sequence continues.
REQ-026 err_clr clears overrun and timeout_err; an error event in the same cycle wins (flag stays 1).
REQ-027 done1/done2 outside their WAIT state are ignored.
REQ-028 No arithmetic; data passes unmodified, DATA_W bits throughout.

Reset
REQ-029 Reset returns FSM to IDLE, clears x_reg, s1_reg, y_out, en_reg, counters, out_valid, trig1, trig2, busy, overrun, timeout_err.
REQ-030 Reset mid-sequence aborts immediately; no out_valid is produced for the aborted sample.

Structure
REQ-031 State encoding and default HOLD_CYC/TIMEOUT constants live in shared package filt_sched_pkg.
REQ-032 Single sub-module wait_timer (clear, enable, count-reached output) used for the WAIT counter; notch stages are instantiated outside this block.

Verification
REQ-033 Both enabled, stub stages return done 1 cycle after trig, dout = din+1; x_in=100 -> y_out=102, out_valid at c7, busy low at c10.
REQ-034 stage_en=2'b00, x_in=-5 -> no trig1/trig2, y_out=-5, out_valid pulses once.
REQ-035 stage_en=2'b01, x_in=7, stub +1 -> trig1 only, y_out=8.
REQ-036 done2 held low -> timeout_err=1 after 8 WAIT2 cycles, no out_valid, FSM IDLE; err_clr -> timeout_err=0.
REQ-037 frame_valid pulses at c0 and c3 -> second sample dropped, overrun=1, first result unaffected.
REQ-038 reset asserted at c5 -> all outputs 0 within the same cycle; a new frame afterwards completes normally.
